// File: rtl/r_box_engine.sv
// Purpose : iterative per-byte rotate-left / XOR-round engine with a saturating round count.
// Latency : Neff cycles from accept to out_valid (one cycle when Neff==0), one round per BUSY cycle.
// Backpr. : one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module r_box_engine #(
    parameter int BYTES      = 4,
    parameter int MAX_ROUNDS = 8,
    localparam int W         = 8 * BYTES,
    localparam int RW        = $clog2(MAX_ROUNDS) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_word,
    input  logic [2:0]    in_func,
    input  logic [RW-1:0] in_rounds,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_word,
    output logic          out_sat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [RW-1:0] MAX_R = RW'(MAX_ROUNDS);

    state_t        state_q, state_d;
    logic [W-1:0]  word_q,  word_d;
    logic [2:0]    func_q,  func_d;
    logic [RW-1:0] neff_q,  neff_d;
    logic [RW-1:0] r_q,     r_d;
    logic          sat_q,   sat_d;

    // Round index k = r+1; only its low byte is mixed into the lanes.
    logic [RW-1:0] r_next;
    logic [7:0]    k8;
    logic [W-1:0]  round_word;

    // Request-side clamp of the round count.
    logic          sat_in;
    logic [RW-1:0] neff_in;

    // Rotate one byte left by s; bits never leave the byte.
    function automatic logic [7:0] rotl8(input logic [7:0] b, input logic [2:0] s);
        logic [15:0] d;
        d = {b, b} << s;
        return d[15:8];
    endfunction

    assign r_next  = r_q + 1'b1;
    assign k8      = 8'(r_next);
    assign sat_in  = (in_rounds > MAX_R);
    assign neff_in = sat_in ? MAX_R : in_rounds;

    // One round applied independently to every byte lane of the working word.
    always_comb begin
        round_word = '0;
        for (int i = 0; i < BYTES; i++) begin
            round_word[8*i +: 8] = rotl8(word_q[8*i +: 8], func_q) ^ k8;
        end
    end

    // State and datapath registers; reset clears everything so outputs drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            func_q  <= '0;
            neff_q  <= '0;
            r_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            func_q  <= func_d;
            neff_q  <= neff_d;
            r_q     <= r_d;
            sat_q   <= sat_d;
        end
    end

    // Next-state and datapath update: accept in IDLE, iterate in BUSY, hold until drained in DONE.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        func_d  = func_q;
        neff_d  = neff_q;
        r_d     = r_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_word;
                    func_d  = in_func;
                    neff_d  = neff_in;
                    sat_d   = sat_in;
                    r_d     = '0;
                    state_d = (neff_in == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                r_d    = r_next;
                word_d = round_word;
                if (r_next == neff_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // No accept here: in_ready is low for the whole DONE state.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags are pure decodes of the registered state.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_word  = word_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_r_box_engine.sv
module tb_r_box_engine;

    localparam int BYTES      = 4;
    localparam int MAX_ROUNDS = 8;
    localparam int W          = 8 * BYTES;
    localparam int RW         = $clog2(MAX_ROUNDS) + 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_word;
    logic [2:0]    in_func;
    logic [RW-1:0] in_rounds;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_word;
    logic          out_sat;

    int checks = 0;
    int errors = 0;

    r_box_engine #(.BYTES(BYTES), .MAX_ROUNDS(MAX_ROUNDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_func   (in_func),
        .in_rounds (in_rounds),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge; returns #1 after the accept edge (edge 0).
    task automatic start(input logic [W-1:0] w, input logic [2:0] f, input logic [RW-1:0] n);
        @(negedge clk);
        chk("ready_before_accept", {63'd0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        in_word   = w;
        in_func   = f;
        in_rounds = n;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_word   = ~w;
        in_func   = f + 3'd1;
        in_rounds = '0;
    endtask

    // Count edges after the accept edge until out_valid is seen, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("pop_in_ready", {63'd0, in_ready}, 64'd1);
        chk("pop_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] w, input logic [2:0] f,
                          input logic [RW-1:0] n, input logic [W-1:0] exp_w,
                          input logic exp_sat, input int exp_lat);
        int lat;
        start(w, f, n);
        wait_done(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_word"}, 64'(out_word), 64'(exp_w));
        chk({tag, "_sat"}, {63'd0, out_sat}, {63'd0, exp_sat});
        pop();
    endtask

    initial begin
        int lat;
        int vcount;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        in_func   = '0;
        in_rounds = '0;
        out_ready = 1'b0;

        // Reset state, before any clock edge.
        #3;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_word", 64'(out_word), 64'd0);
        chk("rst_out_sat", {63'd0, out_sat}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single round, XOR only.
        run_op("n1_zero", 32'h0000_0000, 3'd0, 4'd1, 32'h0101_0101, 1'b0, 1);

        // Two rounds with rotate 3, including the intermediate word.
        start(32'h0000_00FF, 3'd3, 4'd2);
        @(posedge clk);
        #1;
        chk("r1_word", 64'(out_word), 64'h0000_0000_0101_01FE);
        chk("r1_not_done", {63'd0, out_valid}, 64'd0);
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("n2_lat", 64'(lat), 64'd2);
        chk("n2_word", 64'(out_word), 64'h0000_0000_0A0A_0AF5);
        chk("n2_sat", {63'd0, out_sat}, 64'd0);
        pop();

        // Zero rounds: passthrough one cycle after accept.
        run_op("n0", 32'h1234_5678, 3'd5, 4'd0, 32'h1234_5678, 1'b0, 0);

        // Clamped: 12 requested, 8 applied; XOR of 1..8 is 8.
        run_op("sat12", 32'h0000_0000, 3'd0, 4'd12, 32'h0808_0808, 1'b1, 8);

        // Lane isolation at the lane edges.
        run_op("lanes", 32'h8000_0001, 3'd1, 4'd1, 32'h0001_0103, 1'b0, 1);

        // Maximum rotate.
        run_op("rot7", 32'hA5A5_A5A5, 3'd7, 4'd1, 32'hD3D3_D3D3, 1'b0, 1);

        // Stall in DONE for 5 cycles with in_valid pulses that must be ignored.
        start(32'h1122_3344, 3'd0, 4'd8);
        wait_done(lat);
        chk("stall_lat", 64'(lat), 64'd8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = (i % 2 == 0);
            in_word   = 32'hDEAD_BEEF;
            in_rounds = 4'd1;
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_word", 64'(out_word), 64'h0000_0000_192A_3B4C);
            chk("stall_sat", {63'd0, out_sat}, 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_end_word", 64'(out_word), 64'h0000_0000_192A_3B4C);
        pop();

        // Back-to-back with out_ready high: one result every N+2 = 3 cycles.
        @(negedge clk);
        in_valid  = 1'b1;
        in_word   = 32'h0000_0000;
        in_func   = 3'd0;
        in_rounds = 4'd1;
        out_ready = 1'b1;
        vcount    = 0;
        for (int e = 0; e < 9; e++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                vcount++;
                chk("b2b_word", 64'(out_word), 64'h0000_0000_0101_0101);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", 64'(vcount), 64'd3);
        @(posedge clk);
        #1;
        chk("b2b_idle", {63'd0, in_ready}, 64'd1);

        // Asynchronous reset mid-BUSY, off the clock edge.
        start(32'h0000_00FF, 3'd3, 4'd12);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_sat", {63'd0, out_sat}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_out_word", 64'(out_word), 64'd0);
        chk("arst_out_sat", {63'd0, out_sat}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (out_valid) vcount++;
        end
        chk("arst_no_result", 64'(vcount), 64'd0);
        run_op("after_rst", 32'h0000_00FF, 3'd3, 4'd2, 32'h0A0A_0AF5, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/r_box_engine.md
R_BOX_ENGINE -- requirements
Module: r_box_engine

Interface
REQ-001 SHALL provide parameter BYTES, default 4, giving the number of byte lanes; data width W = 8*BYTES; legal range 1..16.
REQ-002 SHALL provide parameter MAX_ROUNDS, default 8, giving the maximum rounds per operation; legal range 1..255; RW = $clog2(MAX_ROUNDS)+1.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, with the clock and reset ports named as follows.
REQ-004 clk  input  1  Sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  Asynchronous active-low reset.
REQ-006 in_valid  input  1  Request valid.
REQ-007 in_ready  output  1  Engine can accept a request.
REQ-008 in_word  input  W  Operand; byte lane i = in_word[8i+7:8i].
REQ-009 in_func  input  3  Per-byte rotate-left amount, 0..7.
REQ-010 in_rounds  input  RW  Requested round count N.
REQ-011 out_valid  output  1  Result valid.
REQ-012 out_ready  input  1  Consumer accepts the result.
REQ-013 out_word  output  W  Result.
REQ-014 out_sat  output  1  The requested N exceeded MAX_ROUNDS and was clamped.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-016 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE); both SHALL be registered-state decodes with no combinational input-to-output path.
REQ-017 Accept SHALL occur on a rising edge with in_valid&&in_ready; the engine SHALL latch in_word, in_func and Neff = min(in_rounds, MAX_ROUNDS), set sat = (in_rounds > MAX_ROUNDS), and clear the round counter r to 0.
REQ-018 On accept, the next state SHALL be DONE if Neff==0, otherwise BUSY.
REQ-019 Each BUSY edge SHALL perform r <= r+1 and apply one round using r+1 as the round index k: every lane b_i <= rotl8(b_i, func) XOR k[7:0].
REQ-020 BUSY SHALL transition to DONE on the edge that applies round Neff; exactly Neff rounds SHALL be applied.
REQ-021 Latency: counting the accept edge as edge 0, out_valid SHALL rise after edge max(Neff,0); Neff==0 SHALL return the unmodified in_word one cycle after accept.
REQ-022 In DONE, out_word and out_sat SHALL hold stable while out_ready==0, for any number of stall cycles.
REQ-023 DONE with out_ready==1 SHALL transition to IDLE on that edge; a new request SHALL NOT be accepted in that same cycle (in_ready==0 in DONE).
REQ-024 in_valid, in_word, in_func and in_rounds SHALL be ignored in BUSY and DONE; operands SHALL NOT change mid-operation.
REQ-025 out_word SHALL be the internal working register at all times; its value outside DONE is don't-care for consumers.
REQ-026 Rotation SHALL stay within each byte lane; no carry or bit movement between lanes.
REQ-027 func==0 SHALL apply only the XOR with k.
REQ-028 Back-to-back throughput SHALL be one operation per Neff+2 cycles when out_ready is held high.

Reset
REQ-029 rst_n low SHALL immediately, without waiting for clk, force state=IDLE, r=0, working word=0, sat=0, in_ready=1, out_valid=0, out_word=0 and out_sat=0.
REQ-030 Reset asserted in BUSY or DONE SHALL abort the operation; no result SHALL be produced after rst_n is released.
REQ-031 The first accept after reset release SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-032 BYTES=4, word 0x00000000, func 0, N=1 -> out_valid after edge 1; out_word 0x01010101; out_sat 0.
REQ-033 Word 0x000000FF, func 3, N=2 -> after round 1 the word is 0x010101FE; final out_word 0x0A0A0AF5.
REQ-034 Word 0x12345678, N=0, any func -> out_valid one cycle after accept; out_word 0x12345678.
REQ-035 N=12 with MAX_ROUNDS=8 -> exactly 8 rounds, out_valid after edge 8, out_sat 1.
REQ-036 Hold out_ready low for 5 cycles in DONE -> out_word, out_valid and out_sat stable, in_ready 0, and in_valid pulses ignored; a later out_ready pulse -> IDLE.
REQ-037 Assert rst_n low mid-BUSY, off a clock edge -> all outputs reach their reset values immediately; after release, a new request completes correctly.
